// File: rtl/sc_peak_frame_aligner.sv
// Schmidl-Cox peak frame aligner: finds the metric peak in a window after the first
// threshold crossing and replays a frame starting at the peak sample from a ring buffer.
module sc_peak_frame_aligner #(
  parameter int unsigned SAMPLE_W = 32,
  parameter int unsigned METRIC_W = 40,
  parameter int unsigned WIN_LEN  = 64,
  parameter int unsigned PKT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic [METRIC_W-1:0] threshold,
  input  logic [PKT_W-1:0]    packet_length,
  input  logic                mode,
  input  logic [METRIC_W-1:0] i_metric,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic                i_tvalid,
  output logic                i_tready,
  output logic [SAMPLE_W-1:0] o_tdata,
  output logic                o_tlast,
  output logic                o_tvalid,
  input  logic                o_tready,
  output logic                busy,
  output logic [31:0]         detect_count
);
  localparam int unsigned DEPTH = 2 * WIN_LEN;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(WIN_LEN) + 1;

  typedef enum logic [1:0] {ST_SEARCH, ST_PEAK, ST_OUTPUT, ST_HOLD} state_t;
  state_t state, state_nxt;

  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [SAMPLE_W-1:0] s1_data;
  logic [AW-1:0]       wp, rp, peak_idx, wp_nxt, peak_idx_nxt;
  logic [AW:0]         occ;
  logic [METRIC_W-1:0] peak_val;
  logic [CW-1:0]       win_cnt;
  logic [PKT_W-1:0]    remaining;
  logic                ready_q, s1_v, s1_last;
  logic                full, in_hs, out_hs, eof, out_free, s1_free, issue, wr_en;
  logic                crossing, new_peak, win_done;

  // Occupancy is tracked as a count so a full buffer is distinct from an empty one.
  assign full         = (occ == (AW+1)'(DEPTH));
  assign i_tready     = ready_q && !((state == ST_OUTPUT) && full);
  assign in_hs        = i_tvalid && i_tready && !clear;
  assign wr_en        = in_hs && (state != ST_HOLD);
  assign wp_nxt       = wr_en ? wp + AW'(1) : wp;
  assign out_hs       = o_tvalid && o_tready;
  assign eof          = out_hs && o_tlast;
  assign out_free     = !o_tvalid || o_tready;
  assign s1_free      = !s1_v || out_free;
  assign issue        = (state == ST_OUTPUT) && (remaining != '0) && (occ != '0) && s1_free;
  assign crossing     = i_metric > threshold;
  assign new_peak     = i_metric > peak_val;
  assign peak_idx_nxt = new_peak ? wp : peak_idx;
  assign win_done     = (win_cnt == CW'(WIN_LEN - 1));

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_SEARCH: if (in_hs && crossing) state_nxt = ST_PEAK;
      ST_PEAK:   if (in_hs && win_done) state_nxt = ST_OUTPUT;
      ST_OUTPUT: if (eof) state_nxt = mode ? ST_SEARCH : ST_HOLD;
      default:   state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      state <= ST_SEARCH;
    else if (clear) state <= ST_SEARCH;
    else            state <= state_nxt;
  end

  // Buffer storage and 1-cycle read stage
  always_ff @(posedge clk) begin
    if (wr_en) mem[wp] <= i_sample;
    if (issue) s1_data <= mem[rp];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q      <= 1'b0;
      busy         <= 1'b0;
      wp           <= '0;
      rp           <= '0;
      occ          <= '0;
      peak_idx     <= '0;
      peak_val     <= '0;
      win_cnt      <= '0;
      remaining    <= '0;
      s1_v         <= 1'b0;
      s1_last      <= 1'b0;
      o_tvalid     <= 1'b0;
      o_tlast      <= 1'b0;
      o_tdata      <= '0;
      detect_count <= '0;
    end else if (clear) begin
      ready_q      <= 1'b1;
      busy         <= 1'b0;
      wp           <= '0;
      rp           <= '0;
      occ          <= '0;
      peak_idx     <= '0;
      peak_val     <= '0;
      win_cnt      <= '0;
      remaining    <= '0;
      s1_v         <= 1'b0;
      s1_last      <= 1'b0;
      o_tvalid     <= 1'b0;
      o_tlast      <= 1'b0;
      o_tdata      <= '0;
      detect_count <= '0;
    end else begin
      ready_q <= 1'b1;
      busy    <= (state_nxt == ST_PEAK) || (state_nxt == ST_OUTPUT);
      wp      <= wp_nxt;

      if ((state == ST_SEARCH) && in_hs && crossing) begin
        peak_val <= i_metric;
        peak_idx <= wp;
        win_cnt  <= CW'(1);
      end

      // The closing beat of the window may itself be the peak, so use the updated index.
      if ((state == ST_PEAK) && in_hs) begin
        win_cnt <= win_cnt + CW'(1);
        if (new_peak) begin
          peak_val <= i_metric;
          peak_idx <= wp;
        end
        if (win_done) begin
          rp        <= peak_idx_nxt;
          occ       <= {1'b0, AW'(wp_nxt - peak_idx_nxt)};
          remaining <= (packet_length == '0) ? PKT_W'(1) : packet_length;
        end
      end

      if (state == ST_OUTPUT) begin
        occ <= occ + (AW+1)'(wr_en) - (AW+1)'(issue);
        if (issue) begin
          rp        <= rp + AW'(1);
          remaining <= remaining - PKT_W'(1);
          s1_last   <= (remaining == PKT_W'(1));
        end
        if (eof) begin
          detect_count <= detect_count + 32'd1;
          rp           <= wp_nxt;
          occ          <= '0;
        end
      end

      if (issue)         s1_v <= 1'b1;
      else if (out_free) s1_v <= 1'b0;

      // Output register only advances when empty or consumed, so data holds under stall.
      if (out_free) begin
        o_tvalid <= s1_v;
        o_tlast  <= s1_v && s1_last;
        if (s1_v) o_tdata <= s1_data;
      end
    end
  end

endmodule

// File: tb/tb_sc_peak_frame_aligner.sv
// Scoreboard bench for sc_peak_frame_aligner: a transaction model predicts each frame
// from the metric stream; a negedge monitor pops and compares every output beat.
module tb_sc_peak_frame_aligner;
  localparam int unsigned SAMPLE_W = 32;
  localparam int unsigned METRIC_W = 40;
  localparam int unsigned WIN_LEN  = 64;
  localparam int unsigned PKT_W    = 16;
  localparam int          WL       = int'(WIN_LEN);

  logic                clk, reset, clear, mode;
  logic [METRIC_W-1:0] threshold, i_metric;
  logic [PKT_W-1:0]    packet_length;
  logic [SAMPLE_W-1:0] i_sample, o_tdata;
  logic                i_tvalid, i_tready, o_tlast, o_tvalid, o_tready, busy;
  logic [31:0]         detect_count;

  int  n_checks, n_fail, n_pops;
  bit  mon_en, rand_rdy, abort, saw_full, held_v;
  logic [SAMPLE_W:0]   held;
  logic [SAMPLE_W:0]   exp_q[$];
  logic [METRIC_W-1:0] mq[$];
  logic [SAMPLE_W-1:0] sq[$];

  sc_peak_frame_aligner #(
    .SAMPLE_W(SAMPLE_W), .METRIC_W(METRIC_W), .WIN_LEN(WIN_LEN), .PKT_W(PKT_W)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .threshold(threshold),
    .packet_length(packet_length), .mode(mode), .i_metric(i_metric),
    .i_sample(i_sample), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .busy(busy), .detect_count(detect_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [METRIC_W-1:0] metric_at(input int kind, input int i);
    int v, d;
    case (kind)
      0: v = i;
      1: v = (i < 280) ? 50 : ((i == 300) ? 500 : 150);
      2: v = (i < 280) ? 50 : ((i == 290 || i == 310) ? 500 : 150);
      3: begin
        d = (i < 550) ? i - 50 : i - 1050;
        if (d < 0) d = -d;
        v = (d <= 10) ? 1000 - 50 * d : 10;
      end
      default: v = (i == 30) ? 5000 : ((i >= 25 && i <= 35) ? 300 : 10);
    endcase
    return METRIC_W'(v);
  endfunction

  task automatic build_stream(input int kind, input int n, input logic [SAMPLE_W-1:0] base);
    mq.delete();
    sq.delete();
    for (int i = 0; i < n; i++) begin
      mq.push_back(metric_at(kind, i));
      sq.push_back(base + SAMPLE_W'(i));
    end
  endtask

  // Reference: first strict crossing, earliest strict maximum over the window, frame from it.
  task automatic model_push(input logic [METRIC_W-1:0] thr, input int len, input bit cont);
    int i, pk, flen;
    logic [METRIC_W-1:0] pv;
    flen = (len == 0) ? 1 : len;
    i = 0;
    while (i < mq.size()) begin
      if (mq[i] > thr && i + WL <= mq.size()) begin
        pk = i;
        pv = mq[i];
        for (int j = i + 1; j < i + WL; j++)
          if (mq[j] > pv) begin
            pv = mq[j];
            pk = j;
          end
        for (int k = 0; k < flen; k++)
          exp_q.push_back({(k == flen - 1), sq[pk + k]});
        if (!cont) break;
        i = (pk + flen > i + WL) ? pk + flen : i + WL;
      end else begin
        i++;
      end
    end
  endtask

  task automatic send_beat(input logic [METRIC_W-1:0] m, input logic [SAMPLE_W-1:0] s);
    int  waits;
    bit  ok;
    waits = 0;
    ok = 1'b0;
    i_metric = m;
    i_sample = s;
    i_tvalid = 1'b1;
    while (!ok && !abort) begin
      @(negedge clk);
      if (abort) break;
      if (i_tready) ok = 1'b1;
      else if (++waits > 3000) begin
        check_eq("send_timeout", 64'(i_tready), 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    i_tvalid = 1'b0;
  endtask

  task automatic drive_all();
    foreach (mq[i]) begin
      if (abort) break;
      send_beat(mq[i], sq[i]);
    end
  endtask

  task automatic wait_drain(input string tag);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 5000) begin
      @(posedge clk);
      cyc++;
    end
    check_eq(tag, 64'(exp_q.size()), 64'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic run_case(input int kind, input int n, input logic [SAMPLE_W-1:0] base,
                          input int len, input bit cont, input string tag);
    threshold     = METRIC_W'(100);
    packet_length = PKT_W'(len);
    build_stream(kind, n, base);
    model_push(threshold, len, cont);
    drive_all();
    wait_drain(tag);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  // Interrupt a 64-sample frame after a few beats with reset or clear.
  task automatic abort_mid_frame(input bit use_reset, input logic [SAMPLE_W-1:0] base);
    int start, cyc;
    threshold     = METRIC_W'(100);
    packet_length = PKT_W'(64);
    build_stream(4, 300, base);
    model_push(threshold, 64, 1'b1);
    start = n_pops;
    cyc   = 0;
    abort = 1'b0;
    fork
      drive_all();
      begin
        while (n_pops < start + 5 && cyc < 3000) begin
          @(posedge clk);
          cyc++;
        end
        check_eq("abort_frame_started", 64'(n_pops >= start + 5), 64'd1);
        if (use_reset) begin
          @(posedge clk);
          #3;
          mon_en = 1'b0;
          abort  = 1'b1;
          reset  = 1'b1;
          #1;
          check_eq("async_rst_tvalid", 64'(o_tvalid), 64'd0);
          check_eq("async_rst_tlast", 64'(o_tlast), 64'd0);
          check_eq("async_rst_tdata", 64'(o_tdata), 64'd0);
          check_eq("async_rst_busy", 64'(busy), 64'd0);
          check_eq("async_rst_count", 64'(detect_count), 64'd0);
          check_eq("async_rst_tready", 64'(i_tready), 64'd0);
        end else begin
          @(posedge clk);
          #1;
          mon_en = 1'b0;
          abort  = 1'b1;
          clear  = 1'b1;
          @(posedge clk);
          #1;
          check_eq("clear_tvalid", 64'(o_tvalid), 64'd0);
          check_eq("clear_tlast", 64'(o_tlast), 64'd0);
          check_eq("clear_tdata", 64'(o_tdata), 64'd0);
          check_eq("clear_busy", 64'(busy), 64'd0);
          check_eq("clear_count", 64'(detect_count), 64'd0);
          clear = 1'b0;
        end
      end
    join
    i_tvalid = 1'b0;
    exp_q.delete();
    if (use_reset) begin
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      check_eq("rst_release_tready", 64'(i_tready), 64'd1);
    end
    abort  = 1'b0;
    mon_en = 1'b1;
    run_case(4, 100, base + 32'h0100_0000, 4, 1'b1, "abort_fresh_drain");
    check_eq("abort_fresh_count", 64'(detect_count), 64'd1);
  endtask

  always @(posedge clk) begin
    #1;
    o_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: signals are stable at negedge for the upcoming edge.
  always @(negedge clk) begin
    if (!mon_en) begin
      held_v = 1'b0;
    end else begin
      if (held_v && o_tvalid) check_eq("stall_stable", 64'({o_tlast, o_tdata}), 64'(held));
      else if (held_v)        check_eq("stall_valid_held", 64'(o_tvalid), 64'd1);
      held_v = 1'b0;
      if (o_tvalid && !o_tready) begin
        held_v = 1'b1;
        held   = {o_tlast, o_tdata};
      end
      if (o_tvalid && o_tready) begin
        n_pops++;
        check_eq("out_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          logic [SAMPLE_W:0] e;
          e = exp_q.pop_front();
          check_eq("frame_data", 64'(o_tdata), 64'(e[SAMPLE_W-1:0]));
          check_eq("frame_last", 64'(o_tlast), 64'(e[SAMPLE_W]));
        end
      end
      if (i_tvalid && !i_tready && !reset) saw_full = 1'b1;
    end
  end

  initial begin
    n_checks = 0; n_fail = 0; n_pops = 0;
    mon_en = 1'b0; rand_rdy = 1'b0; abort = 1'b0; saw_full = 1'b0; held_v = 1'b0;
    held = '0;
    reset = 1'b1; clear = 1'b0; mode = 1'b0;
    i_tvalid = 1'b0; i_metric = '0; i_sample = '0;
    threshold = METRIC_W'(100); packet_length = PKT_W'(8); o_tready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_tvalid", 64'(o_tvalid), 64'd0);
    check_eq("reset_tlast", 64'(o_tlast), 64'd0);
    check_eq("reset_tdata", 64'(o_tdata), 64'd0);
    check_eq("reset_busy", 64'(busy), 64'd0);
    check_eq("reset_count", 64'(detect_count), 64'd0);
    check_eq("reset_tready", 64'(i_tready), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("tready_after_reset", 64'(i_tready), 64'd1);
    mon_en = 1'b1;

    // Ramp: peak is the last window sample; one-shot then HOLD ignores input.
    mode = 1'b0;
    run_case(0, 201, 32'h1000_0000, 8, 1'b0, "ramp_drain");
    check_eq("ramp_count", 64'(detect_count), 64'd1);
    check_eq("hold_busy", 64'(busy), 64'd0);
    check_eq("hold_tready", 64'(i_tready), 64'd1);
    build_stream(4, 100, 32'h1100_0000);
    drive_all();
    repeat (10) @(posedge clk);
    #1;
    check_eq("hold_count", 64'(detect_count), 64'd1);

    // Spike after plateau, then tie between two equal peaks.
    do_clear();
    run_case(1, 400, 32'h2000_0000, 8, 1'b0, "spike_drain");
    check_eq("spike_count", 64'(detect_count), 64'd1);
    do_clear();
    run_case(2, 400, 32'h2100_0000, 8, 1'b0, "tie_drain");
    check_eq("tie_count", 64'(detect_count), 64'd1);

    // Continuous mode, two bursts 1000 samples apart.
    do_clear();
    mode = 1'b1;
    run_case(3, 1200, 32'h3000_0000, 16, 1'b1, "cont_drain");
    check_eq("cont_count", 64'(detect_count), 64'd2);
    check_eq("cont_busy", 64'(busy), 64'd0);

    // Long frame under random backpressure fills the buffer.
    saw_full = 1'b0;
    rand_rdy = 1'b1;
    run_case(4, 400, 32'h4000_0000, 256, 1'b1, "bp_drain");
    rand_rdy = 1'b0;
    check_eq("bp_full_seen", 64'(saw_full), 64'd1);
    check_eq("bp_count", 64'(detect_count), 64'd3);

    // Zero packet length gives a single-sample frame.
    run_case(4, 100, 32'h5000_0000, 0, 1'b1, "len0_drain");
    check_eq("len0_count", 64'(detect_count), 64'd4);

    abort_mid_frame(1'b1, 32'h6000_0000);
    abort_mid_frame(1'b0, 32'h7000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_peak_frame_aligner.md
Name: sc_peak_frame_aligner

Overview:
Parametrised successor to the Schmidl-Cox threshold detector. It consumes a joint stream of timing metric plus sample from the metric calculator. After the first threshold crossing it searches a WIN_LEN-sample window for the true metric peak. It then emits a packet_length-sample frame that starts exactly at the peak sample, replayed from an internal ring buffer. It sits between metric_calculator and the RFNoC output payload stream, and supports one-shot and continuous detection modes.

Parameters:
SAMPLE_W, 32, sample width (packed sc16 I/Q).
METRIC_W, 40, unsigned metric width.
WIN_LEN, 64, peak-search window length in samples; power of 2, at least 4.
PKT_W, 16, width of packet_length.

Ports:
clk  in  1  block clock.
reset  in  1  asynchronous, active-high reset.
clear  in  1  synchronous soft clear of internal state.
threshold  in  METRIC_W  detection threshold, unsigned.
packet_length  in  PKT_W  output frame length in samples; sampled on entry to OUTPUT.
mode  in  1  0 = one-shot, 1 = continuous; sampled at end of frame.
i_metric  in  METRIC_W  metric for the current beat.
i_sample  in  SAMPLE_W  sample aligned with i_metric.
i_tvalid  in  1  input valid.
i_tready  out  1  input ready.
o_tdata  out  SAMPLE_W  output sample.
o_tlast  out  1  last sample of frame.
o_tvalid  out  1  output valid.
o_tready  in  1  output ready.
busy  out  1  high in PEAK or OUTPUT.
detect_count  out  32  number of completed frames; wraps at 2^32.

Behaviour:
- Reset (async) and clear (sync) have identical effect:
  - state = SEARCH.
  - wp, rp, peak_idx, peak_val, counters = 0.
  - o_tvalid = 0, o_tlast = 0, o_tdata = 0, busy = 0, detect_count = 0.
  - i_tready = 0 during reset; 1 from the first cycle after reset deasserts.
- Ring buffer:
  - Depth D = 2*WIN_LEN; 1-cycle read RAM plus output register.
  - Every accepted input beat writes i_sample at wp, then wp++ modulo D.
  - occupancy = (wp - rp) mod D, with a separate full flag.
- SEARCH:
  - i_tready = 1.
  - On an accepted beat with i_metric > threshold (strict): go to PEAK; peak_val = i_metric; peak_idx = wp; win_cnt = 1.
- PEAK:
  - i_tready = 1.
  - Each accepted beat: win_cnt++; if i_metric > peak_val (strict, so the earliest peak wins ties), update peak_val and peak_idx.
  - When the beat that makes win_cnt == WIN_LEN is accepted: go to OUTPUT; rp = peak_idx; remaining = max(packet_length, 1).
- OUTPUT:
  - First o_tvalid is asserted exactly 2 cycles after the transition beat.
  - Samples are emitted in order from rp. o_tdata and o_tlast are held stable while o_tvalid && !o_tready.
  - o_tlast = 1 on the beat where remaining == 1.
  - i_tready = !full. Input keeps being buffered, so samples following the window are replayed in order and none are lost or duplicated.
  - If remaining exceeds the buffered samples, o_tvalid drops until new input arrives; the output bubbles but does not stall the protocol.
- End of frame (o_tlast handshake):
  - detect_count++.
  - mode = 1: go to SEARCH. rp is set to wp (unread buffered samples are discarded). The search restarts on the next new input beat.
  - mode = 0: go to HOLD.
- HOLD:
  - i_tready = 1; input is discarded; o_tvalid = 0.
  - Leaves HOLD only on clear or reset.
- threshold changes take effect on the next input beat. Changes to packet_length or mode in mid-frame do not affect the current frame.
- Simultaneous clear and a handshake: clear wins; the beat is dropped and no count increment occurs.
- Metric comparisons are unsigned and full width; no saturation.

Test Plan:
1. WIN_LEN=64. Metric ramp 0..200 with threshold=100. The crossing occurs at index 101; the ramp peaks at index 164 (last window sample). -> Frame starts with sample 164; packet_length=8 gives 8 beats with o_tlast on the 8th; detect_count=1; state HOLD; further input is ignored.
2. Single spike of 500 at index 300, plateau of 150 elsewhere, threshold 100, crossing at 280. -> Output begins at sample 300. A tie test with two equal peaks at indices 290 and 310 -> output begins at 290.
3. mode=1, two bursts 1000 samples apart, packet_length=16. -> Two frames, each starting at its peak; detect_count=2; no duplicated samples.
4. o_tready toggled randomly at 50% during a 256-sample frame. -> Output order is intact; o_tdata is stable while stalled; i_tready drops when full with occupancy == 128; no loss.
5. packet_length=0. -> A 1-sample frame with o_tlast=1.
6. Reset asserted mid-OUTPUT. -> All outputs are 0 immediately (asynchronously); after release, the block is in SEARCH and a fresh detection works. Repeat the same check with clear.
